// File: rtl/dmem_arb_pkg.sv
//------------------------------------------------------------------------------
// dmem_arb_pkg : shared widths, state and owner encodings for the dmem arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  localparam int DATA_DEPTH   = 1024;
  localparam int REG_WIDTH    = 32;

  localparam int DEF_ADDR_W   = $clog2(DATA_DEPTH);
  localparam int DEF_DATA_W   = REG_WIDTH;
  localparam int DEF_MAX_WAIT = 4;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

  // Counter width able to hold the value sat (inclusive).
  function automatic int cnt_width(input int sat);
    return (sat < 1) ? 1 : $clog2(sat + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arb_starve_cnt.sv
//------------------------------------------------------------------------------
// dmem_arb_starve_cnt : saturating wait counter for a denied debug request
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arb_starve_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] sat_val,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over increment; the counter never runs past sat_val.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_max = (cnt_q >= sat_val);
  assign cnt    = cnt_q;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// dmem_arbiter : core/debug arbiter for a single-port data memory
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_be,
  output logic                core_stall,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,

  input  logic                dbg_req,
  input  logic                dbg_lock,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_be,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,

  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = cnt_width(MAX_WAIT);

  arb_state_t       state_q, state_d;
  logic             core_gnt_w;
  logic             dbg_gnt_w;
  logic             cnt_inc, cnt_clr, cnt_at_max;
  logic [CNT_W-1:0] cnt_val;

  logic [BE_W-1:0]   mux_we;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  logic   rd_fire;
  logic   rd_valid_q;
  owner_t rd_owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    core_gnt_w = 1'b0;
    dbg_gnt_w  = 1'b0;
    case (state_q)
      ARB: begin
        if (cnt_at_max && dbg_req) begin
          dbg_gnt_w = 1'b1;
        end else if (core_req) begin
          core_gnt_w = 1'b1;
        end else if (dbg_req) begin
          dbg_gnt_w = 1'b1;
        end
        if (dbg_gnt_w && dbg_lock) begin
          state_d = LOCK;
        end
      end
      LOCK: begin
        // The release cycle itself still belongs to debug.
        dbg_gnt_w = dbg_req;
        if (!dbg_lock) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign cnt_inc = (state_q == ARB) && dbg_req && !dbg_gnt_w;
  assign cnt_clr = dbg_gnt_w || !dbg_req || (state_q == LOCK);

  dmem_arb_starve_cnt #(
    .CNT_W (CNT_W)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .sat_val (CNT_W'(MAX_WAIT)),
    .cnt     (cnt_val),
    .at_max  (cnt_at_max)
  );

  always_comb begin
    mux_we    = '0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (core_gnt_w) begin
      mux_we    = core_be & {BE_W{core_we}};
      mux_addr  = core_addr;
      mux_wdata = core_wdata;
    end else if (dbg_gnt_w) begin
      mux_we    = dbg_be & {BE_W{dbg_we}};
      mux_addr  = dbg_addr;
      mux_wdata = dbg_wdata;
    end
  end

  // Track who issued the read so the returning word is flagged for that port.
  assign rd_fire = (core_gnt_w && !core_we) || (dbg_gnt_w && !dbg_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_owner_q <= dbg_gnt_w ? OWN_DBG : OWN_CORE;
      end
    end
  end

  // Everything is held quiet while reset is asserted.
  assign core_stall  = !rst && core_req && !core_gnt_w;
  assign dbg_gnt     = !rst && dbg_gnt_w;
  assign mem_en      = !rst && (core_gnt_w || dbg_gnt_w);
  assign mem_we      = rst ? '0 : mux_we;
  assign mem_addr    = rst ? '0 : mux_addr;
  assign mem_wdata   = rst ? '0 : mux_wdata;
  assign core_rvalid = !rst && rd_valid_q && (rd_owner_q == OWN_CORE);
  assign dbg_rvalid  = !rst && rd_valid_q && (rd_owner_q == OWN_DBG);
  assign core_rdata  = rst ? '0 : mem_rdata;
  assign dbg_rdata   = rst ? '0 : mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// tb_dmem_arbiter : directed stimulus with a read-return scoreboard
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [BW-1:0] core_be;
  logic          core_stall, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          dbg_req, dbg_lock, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [BW-1:0] dbg_be;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_be(dbg_be), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory with byte writes and 1-cycle registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      if (mem_we == '0) mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    bit          port;   // 0 = core, 1 = debug
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT returns read data.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("rv_missing_cycle", 64'(cyc), 64'(q[0].cyc));
      void'(q.pop_front());
    end
    if (core_rvalid || dbg_rvalid) begin
      chk("rv_exclusive", {63'b0, core_rvalid & dbg_rvalid}, 64'd0);
      if (q.size() == 0) begin
        chk("rv_unexpected", {62'b0, dbg_rvalid, core_rvalid}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rv_port", {63'b0, dbg_rvalid}, {63'b0, e.port});
        chk("rv_data", {32'b0, e.port ? dbg_rdata : core_rdata}, {32'b0, e.data});
        chk("rv_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic core_off();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_be = '0;
  endtask

  task automatic dbg_off();
    dbg_req = 0; dbg_lock = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_be = '0;
  endtask

  task automatic core_set(input bit we, input int addr, input logic [31:0] d, input logic [3:0] be);
    core_req = 1; core_we = we; core_addr = AW'(addr); core_wdata = d; core_be = be;
  endtask

  task automatic dbg_set(input bit we, input bit lock, input int addr, input logic [31:0] d,
                         input logic [3:0] be);
    dbg_req = 1; dbg_lock = lock; dbg_we = we; dbg_addr = AW'(addr); dbg_wdata = d; dbg_be = be;
  endtask

  task automatic push(input bit port, input logic [31:0] d);
    q.push_back('{port: port, data: d, cyc: cyc + 1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    core_off(); dbg_off();
    rst = 1;
    core_req = 1; dbg_req = 1;
    next(); next();
    @(negedge clk);
    chk("rst_core_stall", {63'b0, core_stall}, 64'd0);
    chk("rst_dbg_gnt",    {63'b0, dbg_gnt},    64'd0);
    chk("rst_mem_en",     {63'b0, mem_en},     64'd0);
    next();
    rst = 0; core_off(); dbg_off();

    // Preload words used by the later tests.
    core_set(1, 1, 32'h0000_0011, 4'hF); next();
    core_set(1, 2, 32'h0000_0022, 4'hF); next();
    core_set(1, 8, 32'h4433_2211, 4'hF); next();
    core_off(); next();

    // Test 1: core write then read back.
    core_set(1, 5, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    chk("t1_mem_we",    {60'b0, mem_we},      64'hF);
    chk("t1_mem_addr",  {54'b0, mem_addr},    64'd5);
    chk("t1_mem_wdata", {32'b0, mem_wdata},   64'hDEAD_BEEF);
    chk("t1_stall_w",   {63'b0, core_stall},  64'd0);
    next();
    core_set(0, 5, 32'h0, 4'hF);
    push(0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_rd_we",     {60'b0, mem_we},      64'd0);
    chk("t1_rd_en",     {63'b0, mem_en},      64'd1);
    chk("t1_stall_r",   {63'b0, core_stall},  64'd0);
    next();
    core_off();
    next();

    // Test 2: starvation with debug held continuously.
    core_set(1, 100, 32'h0, 4'hF);
    dbg_set(1, 0, 200, 32'hA5A5_A5A5, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_dbg_gnt",    {63'b0, dbg_gnt},    {63'b0, (i == 4 || i == 9)});
      chk("t2_core_stall", {63'b0, core_stall}, {63'b0, (i == 4 || i == 9)});
      if (i == 4) chk("t2_mem_addr", {54'b0, mem_addr}, 64'd200);
      next();
    end
    core_off(); dbg_off();
    next();

    // Test 3: core read then debug read on consecutive cycles.
    core_set(0, 1, 32'h0, 4'hF);
    push(0, 32'h11);
    @(negedge clk);
    chk("t3_core_en", {63'b0, mem_en}, 64'd1);
    next();
    core_off();
    dbg_set(0, 0, 2, 32'h0, 4'hF);
    push(1, 32'h22);
    @(negedge clk);
    chk("t3_dbg_gnt", {63'b0, dbg_gnt}, 64'd1);
    next();
    dbg_off();
    next();

    // Test 4: locked debug burst of three writes under continuous core traffic.
    core_set(1, 300, 32'h0000_C0C0, 4'hF);
    for (int i = 0; i < 9; i++) begin
      if (i <= 6) begin
        int w;
        w = (i < 4) ? 0 : i - 4;
        dbg_set(1, (w < 2), 10 + w, 32'(w + 1), 4'hF);
      end else begin
        dbg_off();
      end
      @(negedge clk);
      chk("t4_dbg_gnt",    {63'b0, dbg_gnt},    {63'b0, (i >= 4 && i <= 6)});
      chk("t4_core_stall", {63'b0, core_stall}, {63'b0, (i >= 4 && i <= 6)});
      next();
    end
    core_off(); dbg_off();
    next();
    chk("t4_word0", {32'b0, mem[10]}, 64'd1);
    chk("t4_word1", {32'b0, mem[11]}, 64'd2);
    chk("t4_word2", {32'b0, mem[12]}, 64'd3);

    // Test 5: reset right after a locked debug read.
    dbg_set(0, 1, 2, 32'h0, 4'hF);
    @(negedge clk);
    chk("t5_dbg_gnt", {63'b0, dbg_gnt}, 64'd1);
    next();
    rst = 1; core_req = 1;
    @(negedge clk);
    chk("t5_dbg_rvalid", {63'b0, dbg_rvalid}, 64'd0);
    chk("t5_mem_en",     {63'b0, mem_en},     64'd0);
    chk("t5_dbg_gnt_r",  {63'b0, dbg_gnt},    64'd0);
    next();
    rst = 0; core_off(); dbg_off();
    core_set(0, 1, 32'h0, 4'hF);
    push(0, 32'h11);
    @(negedge clk);
    chk("t5_core_after", {63'b0, core_stall}, 64'd0);
    next();
    core_off();
    next();

    // Test 6: partial store to byte 1, then debug read-back.
    core_set(1, 8, 32'hFFFF_AAFF, 4'h2);
    @(negedge clk);
    chk("t6_mem_we", {60'b0, mem_we}, 64'h2);
    next();
    core_off();
    dbg_set(0, 0, 8, 32'h0, 4'hF);
    push(1, 32'h4433_AA11);
    @(negedge clk);
    chk("t6_dbg_gnt", {63'b0, dbg_gnt}, 64'd1);
    next();
    dbg_off();
    repeat (3) next();

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
